// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle control FSM and the datapath.
// The FSM side (master) samples opcode and drives every strobe and select.
interface multicycle_control_if;
    logic [5:0] opcode;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic [3:0] state;
    logic       illegal_op;

    modport master (
        input  opcode,
        output pc_write,
        output pc_write_cond,
        output i_or_d,
        output mem_read,
        output mem_write,
        output ir_write,
        output mem_to_reg,
        output reg_dst,
        output reg_write,
        output alu_src_a,
        output alu_src_b,
        output alu_op,
        output pc_source,
        output state,
        output illegal_op
    );

    modport slave (
        output opcode,
        input  pc_write,
        input  pc_write_cond,
        input  i_or_d,
        input  mem_read,
        input  mem_write,
        input  ir_write,
        input  mem_to_reg,
        input  reg_dst,
        input  reg_write,
        input  alu_src_a,
        input  alu_src_b,
        input  alu_op,
        input  pc_source,
        input  state,
        input  illegal_op
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle MIPS datapath.
// Outputs are registered decodes of the next state, so they track the state register exactly.
module multicycle_control (
    input logic                  clk,
    input logic                  rst_n,
    multicycle_control_if.master bus
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE   = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_EX   = 4'd10,
        ADDI_WB   = 4'd11,
        IDLE      = 4'd15
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    state_t     state_q;
    state_t     nxt;
    ctrl_t      ctrl_q;
    logic [5:0] op_q;
    logic       illegal_q;

    function automatic logic is_legal(input logic [5:0] op);
        return op inside {OP_R, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW};
    endfunction

    function automatic state_t next_state(
        input state_t     s,
        input logic [5:0] op,
        input logic [5:0] lat
    );
        state_t n;
        n = FETCH;
        case (s)
            IDLE:     n = FETCH;
            FETCH:    n = DECODE;
            DECODE: begin
                case (op)
                    OP_R:         n = EXECUTE;
                    OP_LW, OP_SW: n = MEM_ADDR;
                    OP_BEQ:       n = BRANCH;
                    OP_J:         n = JUMP;
                    OP_ADDI:      n = ADDI_EX;
                    default:      n = FETCH;
                endcase
            end
            // The IR may already hold the next word here; trust the latched copy.
            MEM_ADDR: n = (lat == OP_LW) ? MEM_READ : MEM_WRITE;
            MEM_READ: n = MEM_WB;
            EXECUTE:  n = R_WB;
            ADDI_EX:  n = ADDI_WB;
            default:  n = FETCH;
        endcase
        return n;
    endfunction

    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
                c.alu_src_b = 2'b01;
            end
            DECODE: begin
                c.alu_src_b = 2'b11;
            end
            MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            MEM_READ: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            MEM_WRITE: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            EXECUTE: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            R_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.pc_write_cond = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_source     = 2'b01;
            end
            JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
            end
            ADDI_EX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            ADDI_WB: begin
                c.reg_write = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    assign nxt = next_state(state_q, bus.opcode, op_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ctrl_q    <= '0;
            op_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= nxt;
            ctrl_q    <= decode(nxt);
            illegal_q <= (state_q == DECODE) && !is_legal(bus.opcode);
            if (state_q == DECODE) begin
                op_q <= bus.opcode;
            end
        end
    end

    assign bus.pc_write      = ctrl_q.pc_write;
    assign bus.pc_write_cond = ctrl_q.pc_write_cond;
    assign bus.i_or_d        = ctrl_q.i_or_d;
    assign bus.mem_read      = ctrl_q.mem_read;
    assign bus.mem_write     = ctrl_q.mem_write;
    assign bus.ir_write      = ctrl_q.ir_write;
    assign bus.mem_to_reg    = ctrl_q.mem_to_reg;
    assign bus.reg_dst       = ctrl_q.reg_dst;
    assign bus.reg_write     = ctrl_q.reg_write;
    assign bus.alu_src_a     = ctrl_q.alu_src_a;
    assign bus.alu_src_b     = ctrl_q.alu_src_b;
    assign bus.alu_op        = ctrl_q.alu_op;
    assign bus.pc_source     = ctrl_q.pc_source;
    assign bus.state         = state_q;
    assign bus.illegal_op    = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control.
// Expected per-cycle outputs come from instruction-level state sequences and the output table.
module tb_multicycle_control;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef int iq_t[$];
    typedef struct {
        logic [20:0] v;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;
    bit   running = 0;
    bit   prev_ill = 0;

    function automatic bit legal(input logic [5:0] op);
        return op inside {6'h00, 6'h02, 6'h04, 6'h08, 6'h23, 6'h2B};
    endfunction

    // State visits of one instruction, from its FETCH up to the next FETCH.
    function automatic iq_t seq_for(input logic [5:0] op);
        case (op)
            6'h23:   return '{0, 1, 2, 3, 4};
            6'h2B:   return '{0, 1, 2, 5};
            6'h00:   return '{0, 1, 6, 7};
            6'h04:   return '{0, 1, 8};
            6'h02:   return '{0, 1, 9};
            6'h08:   return '{0, 1, 10, 11};
            default: return '{0, 1};
        endcase
    endfunction

    // {state, illegal, pw, pwc, iord, mr, mw, irw, m2r, rdst, rw, asa, asb, aop, psrc}
    function automatic logic [20:0] expect_vec(input int s, input bit ill);
        logic       pw, pwc, iord, mr, mw, irw, m2r, rdst, rw, asa;
        logic [1:0] asb, aop, ps;
        logic [3:0] st;
        {pw, pwc, iord, mr, mw, irw, m2r, rdst, rw, asa} = '0;
        asb = 2'b00;
        aop = 2'b00;
        ps  = 2'b00;
        st  = 4'(s);
        case (s)
            0:  begin mr = 1; irw = 1; pw = 1; asb = 2'b01; end
            1:  asb = 2'b11;
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mr = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; iord = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rw = 1; rdst = 1; end
            8:  begin asa = 1; pwc = 1; aop = 2'b01; ps = 2'b01; end
            9:  begin pw = 1; ps = 2'b10; end
            10: begin asa = 1; asb = 2'b10; end
            11: rw = 1;
            default: ;
        endcase
        return {st, ill, pw, pwc, iord, mr, mw, irw, m2r, rdst, rw, asa,
                asb, aop, ps};
    endfunction

    function automatic logic [20:0] actual_vec();
        return {bus.state, bus.illegal_op, bus.pc_write, bus.pc_write_cond,
                bus.i_or_d, bus.mem_read, bus.mem_write, bus.ir_write,
                bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                bus.alu_src_b, bus.alu_op, bus.pc_source};
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            checks++;
            if (actual_vec() !== cur.v) begin
                errors++;
                $display("FAIL %s: got %h expected %h", cur.tag, actual_vec(), cur.v);
            end
        end else if (running) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_underflow at %0t", $time);
        end
    end

    task automatic push(input int s, input bit ill, input string tag);
        exp_t e;
        e.v   = expect_vec(s, ill);
        e.tag = tag;
        exp_q.push_back(e);
        running = 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in the first FETCH after release.
    task automatic do_reset(input int n, input string tag);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            push(15, 1'b0, tag);
        end
        rst_n = 1'b1;
        tick();
        prev_ill = 1'b0;
    endtask

    task automatic run_instr(input logic [5:0] op, input int abort_at,
                             input int force_op, input string tag);
        iq_t s;
        s = seq_for(op);
        for (int i = 0; i < s.size(); i++) begin
            push(s[i], (i == 0) && prev_ill, $sformatf("%s_op%02h_st%0d", tag, op, s[i]));
            if (i == 0) begin
                bus.opcode = op;
            end else if (i >= 2) begin
                bus.opcode = (force_op >= 0) ? 6'(force_op) : 6'($urandom);
            end
            if (i == abort_at) begin
                do_reset(1 + int'($urandom_range(1, 0)), $sformatf("%s_reset", tag));
                return;
            end
            tick();
        end
        prev_ill = !legal(op);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] legal_ops [6];
        logic [5:0] op;
        int         ab;
        legal_ops = '{6'h00, 6'h02, 6'h04, 6'h08, 6'h23, 6'h2B};
        bus.opcode = 6'h23;

        do_reset(3, "reset_idle");
        run_instr(6'h23, -1, -1, "lw");
        run_instr(6'h2B, -1, 6'h23, "sw");
        run_instr(6'h00, -1, -1, "rtype");
        run_instr(6'h04, -1, -1, "beq");
        run_instr(6'h02, -1, -1, "j");
        run_instr(6'h3F, -1, -1, "illegal");
        run_instr(6'h08, 2, -1, "addi_abort");
        run_instr(6'h08, -1, -1, "addi");

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(7, 0) < 6) begin
                op = legal_ops[$urandom_range(5, 0)];
            end else begin
                op = 6'($urandom);
            end
            ab = -1;
            if ($urandom_range(9, 0) == 0) begin
                ab = int'($urandom_range(seq_for(op).size() - 1, 0));
            end
            run_instr(op, ab, -1, "rand");
        end

        running = 0;
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle MIPS datapath. It sequences fetch, decode, execute, memory and write-back for each instruction based on the IR opcode. It drives every datapath strobe and mux select, and produces the 2-bit `alu_op` that the ALU control decoder turns into `alu_ctrl` (00 add, 01 subtract, 10 decode funct). It sits between the instruction register and the ALU control decoder / datapath muxes.

## Interface
No parameters.

- `clk` input 1: single system clock; all state changes on its rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `opcode` input 6: IR[31:26]. Sampled only in state DECODE.
- `pc_write` output 1: unconditional PC load.
- `pc_write_cond` output 1: PC load if ALU zero (beq).
- `i_or_d` output 1: memory address select; 0 = PC, 1 = ALUOut.
- `mem_read` output 1: memory read strobe.
- `mem_write` output 1: memory write strobe.
- `ir_write` output 1: IR load.
- `mem_to_reg` output 1: register write-data select; 0 = ALUOut, 1 = MDR.
- `reg_dst` output 1: destination register select; 0 = rt, 1 = rd.
- `reg_write` output 1: register file write enable.
- `alu_src_a` output 1: ALU A select; 0 = PC, 1 = register A.
- `alu_src_b` output 2: ALU B select; 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left by 2.
- `alu_op` output 2: to ALU control; 00 add, 01 sub, 10 funct.
- `pc_source` output 2: PC input select; 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `state` output 4: current state encoding, for debug.
- `illegal_op` output 1: one-cycle pulse on an unsupported opcode.

## Operation
- Moore machine. All outputs are pure decodes of the state register; there is no combinational path from `opcode` to any output.
- Any output not listed for a state is 0.
- State encodings and asserted outputs:
  - IDLE=15: all outputs 0.
  - FETCH=0: `mem_read`, `ir_write`, `pc_write`; `alu_src_b`=01; `alu_op`=00; `pc_source`=00.
  - DECODE=1: `alu_src_b`=11; `alu_op`=00.
  - MEM_ADDR=2: `alu_src_a`; `alu_src_b`=10; `alu_op`=00.
  - MEM_READ=3: `mem_read`, `i_or_d`.
  - MEM_WB=4: `reg_write`, `mem_to_reg`; `reg_dst`=0.
  - MEM_WRITE=5: `mem_write`, `i_or_d`.
  - EXECUTE=6: `alu_src_a`; `alu_src_b`=00; `alu_op`=10.
  - R_WB=7: `reg_write`, `reg_dst`; `mem_to_reg`=0.
  - BRANCH=8: `alu_src_a`, `pc_write_cond`; `alu_src_b`=00; `alu_op`=01; `pc_source`=01.
  - JUMP=9: `pc_write`; `pc_source`=10.
  - ADDI_EX=10: `alu_src_a`; `alu_src_b`=10; `alu_op`=00.
  - ADDI_WB=11: `reg_write`; `reg_dst`=0; `mem_to_reg`=0.
- Transitions:
  - IDLE→FETCH.
  - FETCH→DECODE.
  - DECODE→ by opcode: 0x00 (R-type)→EXECUTE; 0x23 (lw) or 0x2B (sw)→MEM_ADDR; 0x04 (beq)→BRANCH; 0x02 (j)→JUMP; 0x08 (addi)→ADDI_EX; any other→FETCH with `illegal_op` high.
  - MEM_ADDR→MEM_READ if the latched opcode is lw, else MEM_WRITE.
  - MEM_READ→MEM_WB.
  - EXECUTE→R_WB.
  - ADDI_EX→ADDI_WB.
  - MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP, ADDI_WB→FETCH.
- The opcode is latched into an internal register on the DECODE edge. MEM_ADDR uses the latched copy, so the IR may change after DECODE without effect.
- Unused encodings 12–14 → FETCH on the next edge, with outputs all 0 while in them.
- `illegal_op` is registered: high for exactly the one cycle following the DECODE edge (the FETCH cycle). It is 0 otherwise and 0 during reset.

## Timing
- `rst_n` low at a rising edge forces state=IDLE, latched opcode=0 and `illegal_op`=0. Consequently every output is 0 in the cycle after that edge, including `state`=15.
- Reset mid-instruction aborts it immediately. There are no partial writes after the reset edge.
- While `rst_n` is held low, the block stays in IDLE.
- The first FETCH occurs one cycle after the first edge with `rst_n` high.
- Cycles per instruction, counted from entering FETCH to re-entering FETCH:
  - lw: 5
  - sw, R-type, addi: 4
  - beq, j: 3
  - illegal opcode: 2
- `pc_write_cond` is asserted for exactly one cycle in BRANCH. Combining it with the ALU zero flag is the datapath's job.

## Test plan
- Hold `rst_n`=0 for 3 cycles with `opcode`=0x23, then release → all outputs 0 and `state`=15 during reset; FETCH one cycle after release with `mem_read`=`ir_write`=`pc_write`=1, `alu_src_b`=01.
- `opcode`=0x23 (lw) → state sequence 0,1,2,3,4,0; `alu_op`=00 in states 1 and 2; `mem_to_reg`=`reg_write`=1 only in state 4.
- `opcode`=0x2B (sw), with `opcode` changed to 0x23 after DECODE → sequence 0,1,2,5,0; `mem_write`=`i_or_d`=1 in state 5 only; `reg_write` never high.
- `opcode`=0x00 then 0x04 then 0x02 → R-type 0,1,6,7 with `alu_op`=10 in state 6; beq 0,1,8 with `alu_op`=01, `pc_source`=01, `pc_write_cond`=1; j 0,1,9 with `pc_source`=10, `pc_write`=1.
- `opcode`=0x3F → sequence 0,1,0; `illegal_op`=1 for one cycle; no write strobes asserted in DECODE.
- `opcode`=0x08 (addi) with `rst_n` pulled low in state 10 → IDLE on the next edge, `reg_write` never asserted; after release, a full addi runs 0,1,10,11 with `alu_src_b`=10.
